// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer, counting debounce FSM and
// registered press/release strobes for a raw mechanical push-button.
// Optional auto-repeat of btn_pulse while held: define BUTTON_AUTOREPEAT_EN.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic button_raw,
  output logic btn_clean,
  output logic btn_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Reject parameter values the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("HOLD_CYCLES and REPEAT_CYCLES must be at least 1");
  end

  // Saturating increment: the debounce counter never wraps.
  function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
    return (c == CNT_MAX) ? c : c + CW'(1);
  endfunction

  logic          sync1;
  logic          sync2;
  state_t        state;
  logic [CW-1:0] cnt;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] HOLD_LAST   = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CYCLES - 1);

  // rpt counts cycles spent in HELD; rep_phase selects the hold or repeat interval.
  logic [RW-1:0] rpt;
  logic          rep_phase;
`endif

  // Two-flop synchronizer for the asynchronous pad input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM with registered level and single-cycle strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_clean     <= 1'b0;
      btn_pulse     <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
      rpt           <= '0;
      rep_phase     <= 1'b0;
`endif
    end else begin
      btn_pulse     <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          // A single low sample restarts the press count from scratch.
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            btn_clean <= 1'b1;
            btn_pulse <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt       <= '0;
            rep_phase <= 1'b0;
`endif
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        HELD: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= CW'(1);
          end
`ifdef BUTTON_AUTOREPEAT_EN
          else if (rpt == (rep_phase ? REPEAT_LAST : HOLD_LAST)) begin
            btn_pulse <= 1'b1;
            rpt       <= '0;
            rep_phase <= 1'b1;
          end else begin
            rpt <= rpt + RW'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          // A single high sample returns to HELD; the repeat counter restarts.
          if (sync2) begin
            state <= HELD;
            cnt   <= '0;
`ifdef BUTTON_AUTOREPEAT_EN
            rpt       <= '0;
            rep_phase <= 1'b0;
`endif
          end else if (cnt >= CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_clean     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt_inc(cnt);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10, REPEAT_CYCLES=5.
module tb_button_debouncer;

  logic clk;
  logic reset;
  logic button_raw;
  logic btn_clean;
  logic btn_pulse;
  logic release_pulse;

  int nvec;
  int nerr;
  int npulse;
  int nclean;
  int nboth;
  int base_p;
  int base_c;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_raw   (button_raw),
    .btn_clean    (btn_clean),
    .btn_pulse    (btn_pulse),
    .release_pulse(release_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters sampled on the falling edge, away from the active edge.
  initial begin
    npulse = 0;
    nclean = 0;
    nboth  = 0;
  end
  always @(negedge clk) begin
    if (btn_pulse === 1'b1) npulse <= npulse + 1;
    if (btn_clean === 1'b1) nclean <= nclean + 1;
    if (btn_pulse === 1'b1 && release_pulse === 1'b1) nboth <= nboth + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic exp_p;
    nvec = 0;
    nerr = 0;
    reset = 1'b1;
    button_raw = 1'b0;
    cyc(2);
    chk("rst_clean", btn_clean, 0);
    chk("rst_pulse", btn_pulse, 0);
    chk("rst_release", release_pulse, 0);
    reset = 1'b0;
    cyc(2);

    // Clean press: accepted after the 6th edge
    button_raw = 1'b1;
    cyc(5);
    chk("press_e5_pulse", btn_pulse, 0);
    chk("press_e5_clean", btn_clean, 0);
    cyc(1);
    chk("press_e6_pulse", btn_pulse, 1);
    chk("press_e6_clean", btn_clean, 1);
    cyc(1);
    chk("press_e7_pulse", btn_pulse, 0);
    chk("press_e7_clean", btn_clean, 1);

    // Clean release: symmetric latency
    button_raw = 1'b0;
    cyc(5);
    chk("rel_e5_release", release_pulse, 0);
    chk("rel_e5_clean", btn_clean, 1);
    cyc(1);
    chk("rel_e6_release", release_pulse, 1);
    chk("rel_e6_clean", btn_clean, 0);
    cyc(1);
    chk("rel_e7_release", release_pulse, 0);
    cyc(2);

    // Bounce on press: 1,0,0,1,1,1,0 then stable high
    base_p = npulse;
    button_raw = 1'b1; cyc(1);
    button_raw = 1'b0; cyc(2);
    button_raw = 1'b1; cyc(3);
    button_raw = 1'b0; cyc(1);
    button_raw = 1'b1;
    cyc(5);
    chk("bounce_e5_pulse", btn_pulse, 0);
    chk("bounce_e5_clean", btn_clean, 0);
    cyc(1);
    chk("bounce_e6_pulse", btn_pulse, 1);
    chk("bounce_e6_clean", btn_clean, 1);
    cyc(3);
    chk("bounce_pulse_count", npulse - base_p, 1);

    // Release with bounce: 0 for 2, 1 for 2, then stable low
    base_p = npulse;
    button_raw = 1'b0; cyc(2);
    button_raw = 1'b1; cyc(2);
    button_raw = 1'b0;
    cyc(5);
    chk("relb_e5_release", release_pulse, 0);
    chk("relb_e5_clean", btn_clean, 1);
    cyc(1);
    chk("relb_e6_release", release_pulse, 1);
    chk("relb_e6_clean", btn_clean, 0);
    cyc(2);
    chk("relb_no_pulse", npulse - base_p, 0);

    // Glitch rejection: 3-cycle high pulse
    base_p = npulse;
    base_c = nclean;
    button_raw = 1'b1; cyc(3);
    button_raw = 1'b0; cyc(10);
    chk("glitch_pulse_count", npulse - base_p, 0);
    chk("glitch_clean_cycles", nclean - base_c, 0);

    // Reset in PRESS_WAIT with cnt=3, button kept high
    button_raw = 1'b1;
    cyc(5);
    reset = 1'b1;
    #1;
    chk("rstmid_clean", btn_clean, 0);
    chk("rstmid_pulse", btn_pulse, 0);
    chk("rstmid_release", release_pulse, 0);
    cyc(2);
    reset = 1'b0;
    base_p = npulse;
    cyc(5);
    chk("rstmid_e5_pulse", btn_pulse, 0);
    cyc(1);
    chk("rstmid_e6_pulse", btn_pulse, 1);
    chk("rstmid_e6_clean", btn_clean, 1);

    // Asynchronous clear of a held button between clock edges
    #2;
    reset = 1'b1;
    #1;
    chk("async_clean", btn_clean, 0);
    chk("async_pulse", btn_pulse, 0);
    cyc(1);
    reset = 1'b0;
    cyc(5);
    chk("reheld_e5_pulse", btn_pulse, 0);
    cyc(1);
    chk("reheld_e6_pulse", btn_pulse, 1);

    // Long hold: single pulse, or auto-repeat at +10,+15,+20,+25,+30
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
`ifdef BUTTON_AUTOREPEAT_EN
      exp_p = (k >= 10) && ((k - 10) % 5 == 0);
`else
      exp_p = 1'b0;
`endif
      chk($sformatf("hold_k%0d_pulse", k), btn_pulse, exp_p);
    end
    chk("hold_clean", btn_clean, 1);
    button_raw = 1'b0;
    cyc(8);
    chk("final_clean", btn_clean, 0);
    chk("exclusive_pulses", nboth, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Synchronous debounce and edge-detect stage for a raw mechanical push-button, placed directly upstream of the button-driven counter in the message-rotation path. It synchronizes the asynchronous pad input and rejects contact bounce with a counting state machine. It outputs a clean level, suitable as the counter's button edge, plus single-cycle press and release pulses for consumers in the `clk` domain.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized samples required to accept a press or release. Minimum 2. Default is 10 ms at 50 MHz.
- `HOLD_CYCLES`, default 25000000: held time before the first auto-repeat pulse. Used only with `BUTTON_AUTOREPEAT_EN`.
- `REPEAT_CYCLES`, default 10000000: interval between subsequent auto-repeat pulses. Used only with `BUTTON_AUTOREPEAT_EN`.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `button_raw`  in  1  raw pad input; asynchronous, bouncing, active-high.
- `btn_clean`  out  1  registered, debounced button level.
- `btn_pulse`  out  1  one-cycle strobe on accepted press, and on each auto-repeat.
- `release_pulse`  out  1  one-cycle strobe on accepted release.

## Operation
- **Synchronizer:** two-flop chain `sync1` → `sync2`. Only `sync2` feeds the FSM.
- **Counters:**
  - Debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.
  - Repeat counter width is `$clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)`.
- **FSM states:**
  - `IDLE`: `btn_clean=0`.
    - `sync2=1` → `PRESS_WAIT`, with `cnt=1`.
  - `PRESS_WAIT`: `btn_clean=0`.
    - `sync2=1` → `cnt++`.
    - When `cnt` would reach `DEBOUNCE_CYCLES` → `HELD`. Set `btn_clean=1` and `btn_pulse=1` for one cycle. Clear `cnt`.
    - `sync2=0` at any point → `IDLE`, `cnt=0`. No pulse.
  - `HELD`: `btn_clean=1`.
    - `sync2=0` → `RELEASE_WAIT`, with `cnt=1`.
  - `RELEASE_WAIT`: `btn_clean` stays 1.
    - `sync2=0` → `cnt++`.
    - When `cnt` would reach `DEBOUNCE_CYCLES` → `IDLE`. Set `btn_clean=0` and `release_pulse=1` for one cycle.
    - `sync2=1` → back to `HELD`, `cnt=0`. No pulses.
- **Pulse exclusivity:** `btn_pulse` and `release_pulse` are never high in the same cycle.
- **Pulse width:** each pulse is high for exactly one `clk` cycle.
- **Reset:**
  - Sync flops, `cnt`, repeat counter, `btn_clean`, `btn_pulse` and `release_pulse` all go to 0. FSM goes to `IDLE`.
  - Reset mid-debounce discards the partial count.
  - A button still held when reset deasserts is re-debounced from scratch and produces one `btn_pulse`.

## Timing
- Raw rise settles before clock edge E1.
  - `sync2=1` after E2.
  - The first FSM sample is at E3.
  - `btn_clean` and `btn_pulse` are high after edge E(`DEBOUNCE_CYCLES`+2).
- Release latency is symmetric: `release_pulse` and the `btn_clean` fall occur `DEBOUNCE_CYCLES`+2 edges after the raw fall.
- Any input glitch shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- Glitch behaviour is asymmetric between press and release:
  - In `PRESS_WAIT`, a single opposite sample restarts the count. It does not pause it.
  - In `RELEASE_WAIT`, a single high sample returns the FSM to `HELD`.
- All outputs are registered. There is no combinational path from `button_raw` to any output.

## Configuration
- **Macro `BUTTON_AUTOREPEAT_EN` defined:**
  - In `HELD`, the repeat counter runs from 0.
  - `btn_pulse` fires once when it reaches `HOLD_CYCLES`. The counter then reloads and fires every `REPEAT_CYCLES` while in `HELD`.
  - The counter clears on entry to `HELD`, including re-entry from `RELEASE_WAIT`.
  - The counter holds its value during `RELEASE_WAIT`.
- **Macro not defined:**
  - The repeat counter logic is absent.
  - Exactly one `btn_pulse` per accepted press, regardless of hold time.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.

## Test plan
- **Clean press:** `DEBOUNCE_CYCLES`=4, raw 0→1 before E1 and held.
  - `btn_pulse` high for exactly one cycle after E6.
  - `btn_clean`=1 from E6 onward.
- **Bounce on press:** raw toggles 1,0,1,0 at 1–3 cycle intervals, then stable high.
  - Exactly one `btn_pulse`.
  - It arrives 6 edges after the last rising transition.
- **Glitch rejection:** 3-cycle high glitch with `DEBOUNCE_CYCLES`=4 → no `btn_pulse`, `btn_clean` stays 0.
- **Release with bounce:** from `HELD`, raw goes 0,1 (2 cycles), then 0 stable.
  - No extra `btn_pulse`.
  - One `release_pulse` 6 edges after the final fall.
  - `btn_clean`=0 from the same edge.
- **Reset mid-operation:** assert `reset` in `PRESS_WAIT` at `cnt`=3.
  - All outputs 0 immediately, asynchronously.
  - With raw held high, one `btn_pulse` arrives 6 edges after `reset` deasserts.
- **Auto-repeat** (`BUTTON_AUTOREPEAT_EN`, `HOLD_CYCLES`=10, `REPEAT_CYCLES`=5), button held for 30 cycles after acceptance:
  - `btn_pulse` at acceptance, then at +10, +15, +20, +25, +30.
  - Without the macro: a single pulse.
